// File: rtl/golden_nonce_uart_tx.sv
// -----------------------------------------------------------------------------
// golden_nonce_uart_tx
//
// Queues 32-bit golden nonces from a miner and sends each one over an 8N1 UART
// line, least-significant byte first. Each byte is sent LSB first. Each nonce
// is sent as four back-to-back 10-bit characters, which is 40 bit periods. One
// idle cycle (tx high) follows every nonce before the next queued nonce starts.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   FIFO_LOG2     log2 of the nonce FIFO depth
//
// Ports
//   clk           clock; all state changes on the rising edge
//   rst_n         synchronous active-low reset
//   golden_valid  single-cycle strobe: golden_nonce holds a new nonce
//   golden_nonce  32-bit nonce, captured when golden_valid=1
//   tx            serial output, idle high
//   busy          FIFO non-empty or a frame in progress
//   overflow      sticky: a nonce was dropped because the FIFO was full
//   fifo_count    nonces queued and not yet started
// -----------------------------------------------------------------------------
module golden_nonce_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_LOG2    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               golden_valid,
  input  logic [31:0]        golden_nonce,
  output logic               tx,
  output logic               busy,
  output logic               overflow,
  output logic [FIFO_LOG2:0] fifo_count
);

  localparam int                   DEPTH      = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   FULL_COUNT = (FIFO_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_LOG2:0]   CNT_ONE    = (FIFO_LOG2 + 1)'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE    = FIFO_LOG2'(1);
  localparam logic [15:0]          LAST_TICK  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  // FIFO
  logic [31:0]          mem_q [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_LOG2:0]   count_q, count_d;
  logic                 overflow_q, overflow_d;
  logic                 fifo_empty, fifo_full, push, pop;

  // Transmitter
  state_e      state_q, state_d;
  logic        tx_q, tx_d;
  logic [31:0] shift_q, shift_d;
  logic [15:0] tick_q, tick_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        tick_last;

  // ---------------------------------------------------------------------------
  // FIFO control. A pop only happens in IDLE. A push into a full FIFO is
  // accepted when that same edge pops, because the slot being freed is the one
  // being written.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_COUNT);
    pop        = (state_q == IDLE) && !fifo_empty;
    push       = golden_valid && (!fifo_full || pop);

    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A strobe that was not pushed was dropped.
    overflow_d = overflow_q | (golden_valid & ~push);
  end

  // NOTE: the nonce storage has no reset. The pointers and the count define
  // which entries are valid, so clearing them empties the FIFO.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= golden_nonce;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM. tx is registered, so each state sets tx_d to the level the
  // line must carry from the next edge. The shift register moves right once
  // per data bit. After eight shifts, bit 0 holds the first bit of the next
  // byte, so the byte index only counts bytes.
  // ---------------------------------------------------------------------------
  assign tick_last = (tick_q == LAST_TICK);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    shift_d    = shift_q;
    tick_d     = tick_q;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;

    // The bit-period counter restarts from zero on every bit boundary, so the
    // bit timing does not drift.
    if (state_q != IDLE) begin
      tick_d = tick_last ? 16'd0 : tick_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (pop) begin
          shift_d    = mem_q[rd_ptr_q];
          byte_idx_d = 2'd0;
          bit_idx_d  = 3'd0;
          tick_d     = 16'd0;
          tx_d       = 1'b0;
          state_d    = START;
        end
      end

      START: begin
        if (tick_last) begin
          bit_idx_d = 3'd0;
          tx_d      = shift_q[0];
          state_d   = DATA;
        end
      end

      DATA: begin
        if (tick_last) begin
          shift_d = {1'b0, shift_q[31:1]};
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            tx_d      = shift_q[1];
          end
        end
      end

      STOP: begin
        if (tick_last) begin
          if (byte_idx_q == 2'd3) begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
            tx_d       = 1'b0;
            state_d    = START;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers with synchronous reset. Reset takes priority over any
  // strobe in the same cycle and abandons any frame in progress.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: use non-blocking assignments so every register samples the values
    // from before the edge, whatever order the statements are in.
    if (!rst_n) begin
      state_q    <= IDLE;
      tx_q       <= 1'b1;
      shift_q    <= '0;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      shift_q    <= shift_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_golden_nonce_uart_tx
//
// Bench for golden_nonce_uart_tx with CLKS_PER_BIT=4 and FIFO_LOG2=2.
// The reference model is a queue of accepted nonces plus a frame offset. The
// expected tx level comes from that offset: bit = offset / CLKS_PER_BIT, and
// slot = bit % 10, where slot 0 is the start bit, slot 9 is the stop bit and
// the other slots carry data bits. On every falling edge, tx, busy, overflow
// and fifo_count are compared against the model. Directed scenarios decode
// frames from tx and pin the results to hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_golden_nonce_uart_tx;

  localparam int CPB        = 4;
  localparam int LOG2       = 2;
  localparam int DEPTH      = 1 << LOG2;
  localparam int FRAME      = 40 * CPB;
  localparam int WAIT_LIMIT = 10 * FRAME;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            golden_valid;
  logic [31:0]     golden_nonce;
  logic            tx;
  logic            busy;
  logic            overflow;
  logic [LOG2:0]   fifo_count;

  always #5 clk = ~clk;

  golden_nonce_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_LOG2   (LOG2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .golden_valid(golden_valid),
    .golden_nonce(golden_nonce),
    .tx          (tx),
    .busy        (busy),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: no event within %0d cycles (t=%0t)", name, WAIT_LIMIT, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [31:0] m_q[$];
  bit          m_active = 1'b0;
  int          m_off    = 0;
  logic [31:0] m_nonce  = '0;
  bit          m_ovf    = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q.delete();
      m_active = 1'b0;
      m_off    = 0;
      m_ovf    = 1'b0;
    end else begin
      if (m_active) begin
        m_off++;
        if (m_off == FRAME) m_active = 1'b0;
      end else if (m_q.size() > 0) begin
        m_nonce  = m_q.pop_front();
        m_active = 1'b1;
        m_off    = 0;
      end
      if (golden_valid) begin
        if (m_q.size() < DEPTH) m_q.push_back(golden_nonce);
        else m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_tx();
    int b;
    int pos;
    if (!m_active) return 1'b1;
    b   = m_off / CPB;
    pos = b % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return m_nonce[(b / 10) * 8 + pos - 1];
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("tx", tx, exp_tx());
      check("busy", busy, (m_active || m_q.size() > 0) ? 1 : 0);
      check("overflow", overflow, m_ovf);
      check("fifo_count", fifo_count, m_q.size());
    end
  end

  int peak = 0;
  bit track_peak = 1'b0;
  always @(negedge clk) begin
    if (track_peak && int'(fifo_count) > peak) peak = int'(fifo_count);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all called on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [31:0] nonce);
    golden_valid = 1'b1;
    golden_nonce = nonce;
    @(negedge clk);
    golden_valid = 1'b0;
    golden_nonce = $urandom;
  endtask

  task automatic wait_tx_low(input string name, output int waited);
    waited = 0;
    while (tx !== 1'b0 && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) timeout(name);
  endtask

  // Starts t0 samples after the first start-bit sample and reads each bit at
  // its centre.
  task automatic decode_frame(input int t0, output logic [31:0] word,
                              output logic ok, output int t_end);
    int t;
    int pos;
    t    = t0;
    word = '0;
    ok   = 1'b1;
    for (int b = 0; b < 40; b++) begin
      while (t < b * CPB + CPB / 2) begin
        @(negedge clk);
        t++;
      end
      pos = b % 10;
      if (pos == 0) begin
        if (tx !== 1'b0) ok = 1'b0;
      end else if (pos == 9) begin
        if (tx !== 1'b1) ok = 1'b0;
      end else begin
        word[(b / 10) * 8 + pos - 1] = tx;
      end
    end
    t_end = t;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] word;
    logic        ok;
    int          t_end;
    int          waited;
    int          len;
    int          n;

    rst_n        = 1'b0;
    golden_valid = 1'b0;
    golden_nonce = '0;
    tick(3);
    cmp_en = 1'b1;
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    check("reset_count", fifo_count, 0);
    rst_n = 1'b1;
    tick(2);

    // Single nonce: latency, byte order, frame length.
    strobe(32'h1234_5678);
    check("t1_count_after_push", fifo_count, 1);
    check("t1_tx_still_idle", tx, 1);
    @(negedge clk);
    check("t1_latency", tx, 0);
    decode_frame(0, word, ok, t_end);
    check("t1_word", word, 32'h1234_5678);
    check("t1_framing", ok, 1);
    len = t_end;
    while (busy === 1'b1 && len < WAIT_LIMIT) begin
      @(negedge clk);
      len++;
    end
    check("t1_frame_len", len, FRAME);
    check("t1_busy_low", busy, 0);
    tick(2);

    // Back-to-back strobes: order and one idle cycle between frames.
    peak = 0;
    track_peak = 1'b1;
    golden_valid = 1'b1;
    golden_nonce = 32'hA;
    @(negedge clk);
    golden_nonce = 32'hB;
    @(negedge clk);
    golden_nonce = 32'hC;
    @(negedge clk);
    golden_valid = 1'b0;
    decode_frame(1, word, ok, t_end);
    check("t2_word_a", word, 32'hA);
    check("t2_framing_a", ok, 1);
    wait_tx_low("t2_start_b", waited);
    check("t2_gap_b", t_end + waited, FRAME + 1);
    decode_frame(0, word, ok, t_end);
    check("t2_word_b", word, 32'hB);
    wait_tx_low("t2_start_c", waited);
    check("t2_gap_c", t_end + waited, FRAME + 1);
    decode_frame(0, word, ok, t_end);
    check("t2_word_c", word, 32'hC);
    track_peak = 1'b0;
    check("t2_peak_count", peak, 2);
    wait_idle("t2_drain");
    tick(2);

    // Overflow: six strobes, one in flight plus four queued, the sixth dropped.
    for (int i = 0; i < 6; i++) begin
      golden_valid = 1'b1;
      golden_nonce = $urandom;
      @(negedge clk);
    end
    golden_valid = 1'b0;
    check("t3_overflow_set", overflow, 1);
    check("t3_count_full", fifo_count, DEPTH);
    wait_idle("t3_drain");
    check("t3_overflow_sticky", overflow, 1);
    tick(2);

    // Reset, then fill the FIFO and push on the exact pop edge.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t4_overflow_cleared", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      golden_valid = 1'b1;
      golden_nonce = 32'h4000_0000 + i;
      @(negedge clk);
    end
    golden_valid = 1'b0;
    check("t4_count_full", fifo_count, DEPTH);
    n = 0;
    while (!(!m_active && m_q.size() == DEPTH) && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_LIMIT) timeout("t4_wait_pop_edge");
    strobe(32'h4000_00FF);
    check("t4_count_held", fifo_count, DEPTH);
    check("t4_no_overflow", overflow, 0);
    wait_idle("t4_drain");
    check("t4_no_overflow_end", overflow, 0);
    tick(2);

    // Reset during DATA of byte 2; a strobe during reset is ignored.
    strobe(32'h89AB_CDEF);
    n = 0;
    while (!(m_active && m_off == 22 * CPB) && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_LIMIT) timeout("t5_wait_byte2");
    rst_n        = 1'b0;
    golden_valid = 1'b1;
    golden_nonce = 32'h0000_0055;
    @(negedge clk);
    rst_n        = 1'b1;
    golden_valid = 1'b0;
    check("t5_tx", tx, 1);
    check("t5_busy", busy, 0);
    check("t5_count", fifo_count, 0);
    tick(3);
    check("t5_strobe_ignored", busy, 0);
    strobe(32'hCAFE_F00D);
    wait_tx_low("t5_restart", waited);
    check("t5_restart_latency", waited, 1);
    decode_frame(0, word, ok, t_end);
    check("t5_word", word, 32'hCAFE_F00D);
    check("t5_framing", ok, 1);
    wait_idle("t5_drain");
    tick(2);

    // All-zero and all-one nonces.
    strobe(32'h0000_0000);
    wait_tx_low("t6_start_zero", waited);
    decode_frame(0, word, ok, t_end);
    check("t6_word_zero", word, 32'h0000_0000);
    check("t6_framing_zero", ok, 1);
    wait_idle("t6_drain_zero");
    strobe(32'hFFFF_FFFF);
    wait_tx_low("t6_start_ones", waited);
    decode_frame(0, word, ok, t_end);
    check("t6_word_ones", word, 32'hFFFF_FFFF);
    check("t6_framing_ones", ok, 1);
    wait_idle("t6_drain_ones");
    tick(2);

    // Random strobes and bursts, with rare resets.
    for (int i = 0; i < 2500; i++) begin
      golden_valid = ($urandom_range(0, 29) == 0) || (i % 600 < 8);
      golden_nonce = $urandom;
      rst_n        = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    golden_valid = 1'b0;
    rst_n        = 1'b1;
    wait_idle("t7_drain");
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule

// File: doc/golden_nonce_uart_tx.md
GOLDEN_NONCE_UART_TX -- requirements
Module: golden_nonce_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_LOG2, default 2, log2 of nonce FIFO depth (depth 4 by default).
REQ-003 Clock and reset: one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 golden_valid  input  1  single-cycle strobe; the miner found a golden ticket.
REQ-007 golden_nonce  input  32  nonce value, valid when golden_valid=1.
REQ-008 tx  output  1  serial line, 8N1 framing, idle high.
REQ-009 busy  output  1  high when the FIFO is non-empty or a frame is in progress.
REQ-010 overflow  output  1  sticky flag: a nonce was dropped because the FIFO was full.
REQ-011 fifo_count  output  FIFO_LOG2+1  number of nonces queued and not yet started.

Function
REQ-012 FIFO push on golden_valid=1 when not full; golden_nonce is captured in the same edge.
REQ-013 golden_valid=1 while the FIFO is full with no same-cycle pop: nonce dropped; overflow set to 1 and held until reset.
REQ-014 Push and pop in the same cycle: both take effect; fifo_count unchanged; no overflow, including when full.
REQ-015 FIFO pointers wrap modulo 2^FIFO_LOG2; order is strictly first-in first-out.
REQ-016 FSM states: IDLE, START, DATA, STOP.
REQ-017 IDLE with FIFO non-empty: pop the head into a 32-bit shift register, set byte index 0, go to START; tx goes low on that same edge.
REQ-018 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-019 DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles, then STOP.
REQ-020 STOP: tx=1 for CLKS_PER_BIT cycles.
REQ-021 At the end of STOP, if byte index < 3: increment it, go to START (no gap). If byte index = 3: go to IDLE.
REQ-022 Byte order is little-endian: nonce[7:0], [15:8], [23:16], [31:24].
REQ-023 One nonce frame SHALL occupy exactly 40*CLKS_PER_BIT cycles of tx activity.
REQ-024 After a frame, IDLE lasts exactly one cycle (tx=1) before the next queued nonce starts.
REQ-025 Latency: with the FSM in IDLE and the FIFO empty, golden_valid sampled at edge E0 SHALL drive tx low from edge E1.
REQ-026 The bit counter is 16 bits wide; the bit-period counter reloads on each bit boundary and accumulates no drift.
REQ-027 golden_valid during transmission never disturbs the frame in progress.

Reset
REQ-028 rst_n=0 at a rising edge: the following SHALL take effect on that edge, including mid-frame.
- state=IDLE, tx=1, busy=0, overflow=0, fifo_count=0
- FIFO emptied; counters and shift register cleared
- a partially sent frame is abandoned, not resumed
REQ-029 golden_valid is ignored in any cycle where rst_n=0.

Verification
REQ-030 Single nonce, CLKS_PER_BIT=4: one golden_valid with nonce 0x12345678 -> tx low one cycle later; bytes 0x78,0x56,0x34,0x12 decoded; 160 cycles; busy then low.
REQ-031 Back-to-back: 3 strobes (0xA, 0xB, 0xC) on consecutive cycles -> fifo_count peaks at 2 (first popped immediately); frames sent in order, each separated by exactly one idle cycle.
REQ-032 Overflow, FIFO_LOG2=2: 6 strobes while the first frame is in progress -> 1 in flight plus 4 queued; 6th dropped; overflow=1 and stays 1 after all frames drain.
REQ-033 Simultaneous push and pop at full: FIFO full, strobe on the exact pop edge -> accepted; overflow stays 0; fifo_count stays 4.
REQ-034 Reset mid-frame: rst_n=0 during DATA of byte 2 -> next cycle tx=1, busy=0, fifo_count=0; a new strobe after release is sent from byte 0.
REQ-035 Pattern check: nonce 0x00000000 and 0xFFFFFFFF -> correct start and stop bits, each bit exactly CLKS_PER_BIT cycles wide.
